store_commit_buffer: RTL
========================

# store_commit_buffer

Holds executed stores from the load/store execution unit until the reorder buffer retires them, then writes them in program order to data memory through a byte-enabled write port. It is the write-side counterpart of the load path that reads data memory. Stores still speculative when a misprediction is signalled are discarded; retired stores are always written.

## Interface
- DEPTH, 8, number of entries (power of two, ≥2)
- ROB_W, 6, ROB tag width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- mis_pred  in  1  flush all uncommitted entries
- we  in  1  enqueue one executed store
- store_addr  in  32  byte address
- store_data  in  32  store value, right-aligned
- width  in  3  funct3: 000 SB, 001 SH, 010 SW
- rob_dest  in  ROB_W  ROB tag of the store
- commit_valid  in  1  ROB retires a store this cycle
- commit_rob  in  ROB_W  tag being retired
- dmem_ready  in  1  memory accepts the current write
- is_full  out  1  count == DEPTH
- is_empty  out  1  count == 0
- misalign  out  1  one-cycle pulse: rejected enqueue
- dmem_we  out  1  write request
- dmem_write_addr  out  32  {addr[31:2], 2'b00}
- dmem_write_data  out  32  lane-replicated data
- dmem_byte_en  out  4  byte lanes

## Operation
- Circular FIFO: head, tail, count (log2(DEPTH)+1 bits). Entry state FREE / PENDING / COMMITTED; fields addr, data, width, tag.
- Enqueue: we && !is_full && !mis_pred && aligned → entry at tail becomes PENDING, tail+1 mod DEPTH, count+1. we while full: dropped, no state change.
- Alignment: SH requires addr[0]==0; SW requires addr[1:0]==0; width other than 000/001/010 is illegal. Misaligned/illegal with we → not enqueued, misalign=1 next cycle.
- Commit: commit_valid → the PENDING entry whose tag == commit_rob becomes COMMITTED. No match → ignored. In-order retirement guarantees COMMITTED entries are contiguous from head.
- Flush: mis_pred → every PENDING entry becomes FREE; tail = head + number of COMMITTED entries (mod DEPTH); count adjusted. COMMITTED entries and an in-flight write are unaffected.
- Simultaneous: commit_valid and mis_pred same cycle → commit applied first, so that entry survives. we with mis_pred → dropped. Enqueue and drain same cycle → count unchanged.
- Lane formatting at drain (offset = addr[1:0]):
  - SB: byte_en = 4'b0001 << offset, data = {4{data[7:0]}}
  - SH: byte_en = addr[1] ? 4'b1100 : 4'b0011, data = {2{data[15:0]}}
  - SW: byte_en = 4'b1111, data = data
- Drain FSM:
  - IDLE: dmem_we=0; if head entry COMMITTED → load outputs, go WRITE.
  - WRITE: dmem_we=1, address/data/byte_en held stable until dmem_ready. On dmem_ready: head FREE, head+1, count−1; if next entry COMMITTED → load it, stay WRITE; else → IDLE.

## Timing
- All outputs registered except is_full/is_empty (decoded from count register).
- Reset values: is_full=0, is_empty=1, misalign=0, dmem_we=0, dmem_write_addr=0, dmem_write_data=0, dmem_byte_en=0; all entries FREE, head=tail=count=0, FSM IDLE.
- Reset mid-write: dmem_we=0 after the reset edge; in-flight and queued stores are lost.
- Enqueue at edge N → is_empty=0 after N. Commit at edge M → earliest dmem_we=1 in the cycle after M+1.
- Sustained throughput with dmem_ready=1: one write per cycle.
- dmem_ready while dmem_we=0: ignored.

## Test plan
- Reset, then SB addr 0x103 data 0xAB tag 5, commit 5, dmem_ready=1 → one cycle with dmem_we=1, addr 0x100, byte_en 1000, data 0xABABABAB; is_empty=1 afterwards.
- Enqueue 8 SW (tags 0–7) → is_full=1; a 9th we is dropped. Commit all, dmem_ready=1 → 8 back-to-back writes in tag order; head and tail wrap to 0.
- Enqueue tags 1, 2, 3; commit 1; mis_pred → count=1; only tag 1 is written; tags 2/3 never appear on dmem.
- Commit 2 and mis_pred in the same cycle after enqueue of 1, 2, 3 (tag 1 already committed) → tags 1 and 2 written, tag 3 dropped.
- SH to 0x102 data 0x1234 with dmem_ready held low 3 cycles → dmem_we, addr 0x100, byte_en 1100, data 0x12341234 stable for 4 cycles; write retires on cycle 4.
- SW to 0x101, and width=011 → misalign pulses once per request, count stays 0, no dmem write.

Source files
------------

// File: rtl/store_commit_buffer_if.sv
// Store commit buffer bus bundle: store enqueue, ROB retire, flush and data-memory write port.
// Port summary: master = execution/ROB/memory side (drives requests, ready); slave = buffer.
// Status (is_full/is_empty/misalign) and the dmem write request flow from slave to master.
interface store_commit_buffer_if #(
  parameter int ROB_W = 6
);
  logic             mis_pred;
  logic             we;
  logic [31:0]      store_addr;
  logic [31:0]      store_data;
  logic [2:0]       width;
  logic [ROB_W-1:0] rob_dest;
  logic             commit_valid;
  logic [ROB_W-1:0] commit_rob;
  logic             dmem_ready;
  logic             is_full;
  logic             is_empty;
  logic             misalign;
  logic             dmem_we;
  logic [31:0]      dmem_write_addr;
  logic [31:0]      dmem_write_data;
  logic [3:0]       dmem_byte_en;

  modport master (
    output mis_pred, we, store_addr, store_data, width, rob_dest,
           commit_valid, commit_rob, dmem_ready,
    input  is_full, is_empty, misalign, dmem_we, dmem_write_addr,
           dmem_write_data, dmem_byte_en
  );

  modport slave (
    input  mis_pred, we, store_addr, store_data, width, rob_dest,
           commit_valid, commit_rob, dmem_ready,
    output is_full, is_empty, misalign, dmem_we, dmem_write_addr,
           dmem_write_data, dmem_byte_en
  );
endinterface

// File: rtl/store_commit_buffer.sv
// Purpose: holds executed stores until ROB retirement, then writes them in order to dmem.
// Latency: commit at edge M -> dmem_we earliest after edge M+1; one write per cycle sustained.
// Backpressure: dmem_ready low holds the write stable; enqueue while full is silently dropped.
// Ports: clk, reset (sync, active-high); sb = slave view of store_commit_buffer_if
// (enqueue/commit/flush inputs, is_full/is_empty/misalign status, byte-enabled dmem write).
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 6
) (
  input logic                  clk,
  input logic                  reset,
  store_commit_buffer_if.slave sb
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ENT_FREE, ENT_PENDING, ENT_COMMITTED} ent_e;
  typedef enum logic {ST_IDLE, ST_WRITE} fsm_e;

  ent_e             st_q    [DEPTH];
  ent_e             st_d    [DEPTH];
  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [2:0]       width_q [DEPTH];
  logic [ROB_W-1:0] tag_q   [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d, cidx, ld_idx;
  logic [AW:0]   count_q, count_d, ncom;
  fsm_e          fsm_q, fsm_d;
  logic          misalign_q, misalign_d, dmem_we_q, dmem_we_d;
  logic [31:0]   waddr_q, waddr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          full, empty, aligned, do_enq, pop, load, commit_hit;

  assign full                = (count_q == CNT_FULL);
  assign empty               = (count_q == '0);
  assign sb.is_full          = full;
  assign sb.is_empty         = empty;
  assign sb.misalign         = misalign_q;
  assign sb.dmem_we          = dmem_we_q;
  assign sb.dmem_write_addr  = waddr_q;
  assign sb.dmem_write_data  = wdata_q;
  assign sb.dmem_byte_en     = be_q;

  always_comb begin : align_chk
    aligned = 1'b0;
    case (sb.width)
      3'b000:  aligned = 1'b1;
      3'b001:  aligned = ~sb.store_addr[0];
      3'b010:  aligned = (sb.store_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // A flush in the same cycle kills the incoming store as well.
  assign do_enq     = sb.we && !full && !sb.mis_pred && aligned;
  assign misalign_d = sb.we && !aligned;

  // Drain FSM. In WRITE the head entry stays COMMITTED until accepted, so a
  // concurrent flush counts it among the survivors.
  always_comb begin : drain_fsm
    fsm_d     = fsm_q;
    dmem_we_d = dmem_we_q;
    pop       = 1'b0;
    load      = 1'b0;
    ld_idx    = head_q;
    case (fsm_q)
      ST_IDLE: begin
        if (st_q[head_q] == ENT_COMMITTED) begin
          load      = 1'b1;
          dmem_we_d = 1'b1;
          fsm_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (sb.dmem_ready) begin
          pop    = 1'b1;
          ld_idx = head_q + PTR_ONE;
          if (st_q[ld_idx] == ENT_COMMITTED) begin
            load = 1'b1;
          end else begin
            dmem_we_d = 1'b0;
            fsm_d     = ST_IDLE;
          end
        end
      end
      default: begin
        dmem_we_d = 1'b0;
        fsm_d     = ST_IDLE;
      end
    endcase
  end

  always_comb begin : lane_fmt
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (load) begin
      waddr_d = {addr_q[ld_idx][31:2], 2'b00};
      case (width_q[ld_idx])
        3'b000: begin
          be_d    = 4'b0001 << addr_q[ld_idx][1:0];
          wdata_d = {4{data_q[ld_idx][7:0]}};
        end
        3'b001: begin
          be_d    = addr_q[ld_idx][1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{data_q[ld_idx][15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = data_q[ld_idx];
        end
      endcase
    end
  end

  // Order within a cycle: commit, then drain, then flush, then enqueue.
  always_comb begin : queue_upd
    st_d       = st_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    commit_hit = 1'b0;
    ncom       = '0;
    cidx       = '0;
    if (sb.commit_valid) begin
      // Scan from head so a reused tag retires the oldest pending instance.
      for (int i = 0; i < DEPTH; i++) begin
        cidx = head_q + AW'(i);
        if (!commit_hit && st_q[cidx] == ENT_PENDING && tag_q[cidx] == sb.commit_rob) begin
          st_d[cidx] = ENT_COMMITTED;
          commit_hit = 1'b1;
        end
      end
    end
    if (pop) begin
      st_d[head_q] = ENT_FREE;
      head_d       = head_q + PTR_ONE;
      count_d      = count_q - CNT_ONE;
    end
    if (sb.mis_pred) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (st_d[i] == ENT_PENDING) begin
          st_d[i] = ENT_FREE;
        end else if (st_d[i] == ENT_COMMITTED) begin
          ncom = ncom + CNT_ONE;
        end
      end
      // Committed entries are contiguous from head, so they define the new tail.
      tail_d  = head_d + ncom[AW-1:0];
      count_d = ncom;
    end else if (do_enq) begin
      st_d[tail_q] = ENT_PENDING;
      tail_d       = tail_q + PTR_ONE;
      count_d      = count_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin : state_regs
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= ENT_FREE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fsm_q      <= ST_IDLE;
      misalign_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      st_q       <= st_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fsm_q      <= fsm_d;
      misalign_q <= misalign_d;
      dmem_we_q  <= dmem_we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
    end
  end

  // Payload needs no reset: only entries marked PENDING/COMMITTED are ever read.
  always_ff @(posedge clk) begin : payload_regs
    if (do_enq) begin
      addr_q[tail_q]  <= sb.store_addr;
      data_q[tail_q]  <= sb.store_data;
      width_q[tail_q] <= sb.width;
      tag_q[tail_q]   <= sb.rob_dest;
    end
  end
endmodule
